// File: rtl/pdatapath.sv
// Parametrised register-file datapath with A/B operand latches, shifter, ALU,
// C result register and Z/N/V status, sequenced by a command-driven micro-FSM.
module pdatapath #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int PCW  = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_alu_op,
    input  logic [1:0]    cmd_shift,
    input  logic [AW-1:0] cmd_rn,
    input  logic [AW-1:0] cmd_rm,
    input  logic [AW-1:0] cmd_rd,
    input  logic          cmd_a_zero,
    input  logic          cmd_b_imm,
    input  logic [DW-1:0] cmd_imm5,
    input  logic [DW-1:0] cmd_imm8,
    input  logic [1:0]    cmd_wb_sel,
    input  logic          cmd_wr_en,
    input  logic          cmd_flags_en,
    input  logic [DW-1:0] mdata,
    input  logic [PCW-1:0] pc,
    output logic [DW-1:0] datapath_out,
    output logic          Z_out,
    output logic          N_out,
    output logic          V_out,
    output logic          done,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic [2:0]    state;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] reg_a, reg_b, reg_c;
    logic          flag_z, flag_n, flag_v;

    logic [1:0]    c_alu_op, c_shift, c_wb_sel;
    logic [AW-1:0] c_rn, c_rm, c_rd;
    logic          c_a_zero, c_b_imm, c_wr_en, c_flags_en;
    logic [DW-1:0] c_imm5, c_imm8;

    logic          accept;
    logic [DW-1:0] b_shifted, ain, bin, result, wdata;
    logic          res_v;

    assign cmd_ready    = (state == S_IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign done         = (state == S_WB);
    assign datapath_out = reg_c;
    assign Z_out        = flag_z;
    assign N_out        = flag_n;
    assign V_out        = flag_v;
    assign dbg_data     = regs[dbg_addr];

    always_comb begin
        b_shifted = reg_b;
        case (c_shift)
            2'b01:   b_shifted = {reg_b[DW-2:0], 1'b0};
            2'b10:   b_shifted = {1'b0, reg_b[DW-1:1]};
            2'b11:   b_shifted = {reg_b[DW-1], reg_b[DW-1:1]};
            default: b_shifted = reg_b;
        endcase
    end

    // Overflow is judged on the operands actually presented to the ALU.
    always_comb begin
        ain    = c_a_zero ? '0 : reg_a;
        bin    = c_b_imm ? c_imm5 : b_shifted;
        result = '0;
        res_v  = 1'b0;
        case (c_alu_op)
            OP_ADD: begin
                result = ain + bin;
                res_v  = (ain[DW-1] == bin[DW-1]) && (result[DW-1] != ain[DW-1]);
            end
            OP_SUB: begin
                result = ain - bin;
                res_v  = (ain[DW-1] != bin[DW-1]) && (result[DW-1] != ain[DW-1]);
            end
            OP_AND:  result = ain & bin;
            default: result = ~bin;
        endcase
    end

    always_comb begin
        wdata = reg_c;
        case (c_wb_sel)
            2'b01:   wdata = DW'(pc);
            2'b10:   wdata = c_imm8;
            2'b11:   wdata = mdata;
            default: wdata = reg_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_c      <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            c_alu_op   <= '0;
            c_shift    <= '0;
            c_wb_sel   <= '0;
            c_rn       <= '0;
            c_rm       <= '0;
            c_rd       <= '0;
            c_a_zero   <= 1'b0;
            c_b_imm    <= 1'b0;
            c_wr_en    <= 1'b0;
            c_flags_en <= 1'b0;
            c_imm5     <= '0;
            c_imm8     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        c_alu_op   <= cmd_alu_op;
                        c_shift    <= cmd_shift;
                        c_wb_sel   <= cmd_wb_sel;
                        c_rn       <= cmd_rn;
                        c_rm       <= cmd_rm;
                        c_rd       <= cmd_rd;
                        c_a_zero   <= cmd_a_zero;
                        c_b_imm    <= cmd_b_imm;
                        c_wr_en    <= cmd_wr_en;
                        c_flags_en <= cmd_flags_en;
                        c_imm5     <= cmd_imm5;
                        c_imm8     <= cmd_imm8;
                        state      <= (cmd_wb_sel == 2'b00) ? S_LOAD_A : S_WB;
                    end
                end
                S_LOAD_A: begin
                    reg_a <= regs[c_rn];
                    state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    reg_b <= regs[c_rm];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    reg_c <= result;
                    if (c_flags_en) begin
                        flag_z <= (result == '0);
                        flag_n <= result[DW-1];
                        flag_v <= res_v;
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    if (c_wr_en) begin
                        regs[c_rd] <= wdata;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdatapath.sv
// Self-checking bench for pdatapath: table of commands with expected results
// flowing through a scoreboard queue, plus handshake and mid-command reset cases.
module tb_pdatapath;

    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int PCW = 8;

    typedef struct {
        logic [1:0]  wb_sel;
        logic [1:0]  alu_op;
        logic [1:0]  shift;
        logic [2:0]  rn, rm, rd;
        logic        a_zero, b_imm, wr_en, flags_en;
        logic [15:0] imm5, imm8, mdata;
        logic [7:0]  pc;
        logic [15:0] exp_c;
        logic        exp_z, exp_n, exp_v;
        logic [15:0] exp_rd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_alu_op = '0, cmd_shift = '0, cmd_wb_sel = '0;
    logic [AW-1:0] cmd_rn = '0, cmd_rm = '0, cmd_rd = '0, dbg_addr = '0;
    logic          cmd_a_zero = 1'b0, cmd_b_imm = 1'b0, cmd_wr_en = 1'b0, cmd_flags_en = 1'b0;
    logic [DW-1:0] cmd_imm5 = '0, cmd_imm8 = '0, mdata = '0;
    logic [PCW-1:0] pc = '0;
    logic [DW-1:0] datapath_out, dbg_data;
    logic          Z_out, N_out, V_out, done;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs [16];
    vec_t exp_q [$];

    pdatapath #(.DW(DW), .NREG(8), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_alu_op(cmd_alu_op), .cmd_shift(cmd_shift), .cmd_rn(cmd_rn),
        .cmd_rm(cmd_rm), .cmd_rd(cmd_rd), .cmd_a_zero(cmd_a_zero),
        .cmd_b_imm(cmd_b_imm), .cmd_imm5(cmd_imm5), .cmd_imm8(cmd_imm8),
        .cmd_wb_sel(cmd_wb_sel), .cmd_wr_en(cmd_wr_en), .cmd_flags_en(cmd_flags_en),
        .mdata(mdata), .pc(pc), .datapath_out(datapath_out), .Z_out(Z_out),
        .N_out(N_out), .V_out(V_out), .done(done), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t alu_vec(input logic [1:0] op, input logic [1:0] sh,
                                     input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                                     input logic az, input logic bi, input logic [15:0] imm5,
                                     input logic we, input logic fe, input logic [15:0] c,
                                     input logic z, input logic n, input logic v, input logic [15:0] erd);
        vec_t r;
        r.wb_sel = 2'b00; r.alu_op = op; r.shift = sh;
        r.rn = rn; r.rm = rm; r.rd = rd;
        r.a_zero = az; r.b_imm = bi; r.wr_en = we; r.flags_en = fe;
        r.imm5 = imm5; r.imm8 = 16'h5A5A; r.mdata = 16'h0; r.pc = 8'h0;
        r.exp_c = c; r.exp_z = z; r.exp_n = n; r.exp_v = v; r.exp_rd = erd;
        return r;
    endfunction

    function automatic vec_t wb_vec(input logic [1:0] sel, input logic [2:0] rd,
                                    input logic [15:0] imm8, input logic [15:0] md, input logic [7:0] pcv,
                                    input logic [15:0] c, input logic z, input logic n, input logic v,
                                    input logic [15:0] erd);
        vec_t r;
        r.wb_sel = sel; r.alu_op = 2'b01; r.shift = 2'b01;
        r.rn = rd; r.rm = rd; r.rd = rd;
        r.a_zero = 1'b0; r.b_imm = 1'b1; r.wr_en = 1'b1; r.flags_en = 1'b1;
        r.imm5 = 16'h1234; r.imm8 = imm8; r.mdata = md; r.pc = pcv;
        r.exp_c = c; r.exp_z = z; r.exp_n = n; r.exp_v = v; r.exp_rd = erd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_fields(input vec_t v);
        cmd_alu_op   = v.alu_op;
        cmd_shift    = v.shift;
        cmd_wb_sel   = v.wb_sel;
        cmd_rn       = v.rn;
        cmd_rm       = v.rm;
        cmd_rd       = v.rd;
        cmd_a_zero   = v.a_zero;
        cmd_b_imm    = v.b_imm;
        cmd_wr_en    = v.wr_en;
        cmd_flags_en = v.flags_en;
        cmd_imm5     = v.imm5;
        cmd_imm8     = v.imm8;
        mdata        = v.mdata;
        pc           = v.pc;
    endtask

    // Called between edges with the DUT expected idle; returns just after the accepting edge.
    task automatic apply_stimulus(input vec_t v, input string name);
        drive_fields(v);
        cmd_valid = 1'b1;
        check({name, " ready"}, {31'd0, cmd_ready}, 32'd1);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        cmd_alu_op   = 2'($urandom);
        cmd_shift    = 2'($urandom);
        cmd_wb_sel   = 2'($urandom);
        cmd_rn       = 3'($urandom);
        cmd_rm       = 3'($urandom);
        cmd_rd       = 3'($urandom);
        cmd_a_zero   = 1'($urandom);
        cmd_b_imm    = 1'($urandom);
        cmd_wr_en    = 1'($urandom);
        cmd_flags_en = 1'($urandom);
        cmd_imm5     = 16'($urandom);
        cmd_imm8     = 16'($urandom);
    endtask

    task automatic check_output(input string name);
        vec_t v;
        int   lat;
        int   exp_lat;
        v = exp_q.pop_front();
        exp_lat = (v.wb_sel == 2'b00) ? 3 : 0;
        lat = 0;
        @(negedge clk);
        while (done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 8) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: no done within 8 cycles", name);
            return;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " C"}, datapath_out, v.exp_c);
        check({name, " ZNV"}, {Z_out, N_out, V_out}, {v.exp_z, v.exp_n, v.exp_v});
        @(negedge clk);
        check({name, " done pulse"}, {31'd0, done}, 32'd0);
        check({name, " ready again"}, {31'd0, cmd_ready}, 32'd1);
        dbg_addr = v.rd;
        #1;
        check({name, " rd value"}, dbg_data, v.exp_rd);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " C"}, datapath_out, 32'd0);
        check({name, " ZNV"}, {Z_out, N_out, V_out}, 32'd0);
        check({name, " ready"}, {31'd0, cmd_ready}, 32'd1);
        check({name, " done"}, {31'd0, done}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("%s R%0d", name, i), dbg_data, 32'd0);
        end
    endtask

    initial begin : main
        logic [15:0] final_regs [8];
        vec_t hx, hy, hz;
        int   dn;

        vecs[0]  = wb_vec(2'b10, 3'd0, 16'h0005, 16'h0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0005);
        vecs[1]  = wb_vec(2'b10, 3'd1, 16'h0003, 16'h0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003);
        vecs[2]  = alu_vec(2'b00, 2'b00, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0008);
        vecs[3]  = wb_vec(2'b11, 3'd0, 16'h0, 16'h8000, 8'h00, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h8000);
        vecs[4]  = wb_vec(2'b10, 3'd1, 16'h0001, 16'h0, 8'h00, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0001);
        vecs[5]  = alu_vec(2'b01, 2'b00, 3'd0, 3'd1, 3'd3, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1, 16'h7FFF);
        vecs[6]  = alu_vec(2'b01, 2'b00, 3'd1, 3'd1, 3'd4, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        vecs[7]  = wb_vec(2'b10, 3'd1, 16'h8002, 16'h0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8002);
        vecs[8]  = alu_vec(2'b00, 2'b11, 3'd0, 3'd1, 3'd5, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'hC001, 1'b0, 1'b1, 1'b0, 16'hC001);
        vecs[9]  = alu_vec(2'b00, 2'b10, 3'd0, 3'd1, 3'd5, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h4001, 1'b0, 1'b0, 1'b0, 16'h4001);
        vecs[10] = alu_vec(2'b00, 2'b01, 3'd0, 3'd1, 3'd5, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0004);
        vecs[11] = alu_vec(2'b00, 2'b00, 3'd1, 3'd0, 3'd6, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 16'h8001);
        vecs[12] = alu_vec(2'b11, 2'b00, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'hFFF7, 1'b0, 1'b1, 1'b0, 16'h0008);
        vecs[13] = wb_vec(2'b01, 3'd7, 16'h0, 16'h0, 8'hA5, 16'hFFF7, 1'b0, 1'b1, 1'b0, 16'h00A5);
        vecs[14] = alu_vec(2'b10, 2'b00, 3'd6, 3'd1, 3'd0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h8000);
        vecs[15] = alu_vec(2'b00, 2'b00, 3'd3, 3'd7, 3'd3, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h80A4, 1'b0, 1'b1, 1'b1, 16'h80A4);
        final_regs = '{16'h8000, 16'h8002, 16'h0008, 16'h80A4, 16'h0000, 16'h0004, 16'h8001, 16'h00A5};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("reset");

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
            check_output($sformatf("vec%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("table final R%0d", i), dbg_data, final_regs[i]);
        end

        // cmd_valid stays high; the middle command only sits on the bus during WB.
        hx = wb_vec(2'b10, 3'd0, 16'h1111, 16'h0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        hy = wb_vec(2'b10, 3'd1, 16'h2222, 16'h0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        hz = wb_vec(2'b10, 3'd2, 16'h3333, 16'h0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        dn = 0;
        drive_fields(hx);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) dn++;
        drive_fields(hy);
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) dn++;
        drive_fields(hz);
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) dn++;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) dn++;
        check("held valid done count", dn, 32'd2);
        dbg_addr = 3'd0; #1; check("held valid R0", dbg_data, 32'h1111);
        dbg_addr = 3'd1; #1; check("held valid R1", dbg_data, 32'h8002);
        dbg_addr = 3'd2; #1; check("held valid R2", dbg_data, 32'h3333);

        // Abort an ADD while it is in EXEC.
        apply_stimulus(alu_vec(2'b00, 2'b00, 3'd0, 3'd2, 3'd3, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1,
                               16'h0, 1'b0, 1'b0, 1'b0, 16'h0), "abort");
        void'(exp_q.pop_back());
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        rst_n = 1'b0;
        repeat (3) begin
            #1;
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        check("abort no done", dn, 32'd0);
        check_all_zero("abort");

        apply_stimulus(wb_vec(2'b10, 3'd1, 16'h0007, 16'h0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0007), "post1");
        check_output("post1");
        apply_stimulus(alu_vec(2'b00, 2'b00, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1,
                               16'h000E, 1'b0, 1'b0, 1'b0, 16'h000E), "post2");
        check_output("post2");
        apply_stimulus(alu_vec(2'b01, 2'b00, 3'd0, 3'd1, 3'd4, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1,
                               16'hFFF9, 1'b0, 1'b1, 1'b0, 16'hFFF9), "post3");
        check_output("post3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/pdatapath.md
# pdatapath

Parametrised successor to the lab-6 datapath: an NREG×DW register file, A/B operand latches, shifter, ALU, C result register and Z/N/V status register, sequenced by an internal micro-sequencer. Each command is issued through a valid/ready handshake and completes with a one-cycle `done` pulse. Overflow and negative flags are computed correctly in two's complement. The block sits between the instruction decoder/controller and memory. The controller issues one register-level operation per command instead of driving individual load enables.

## Interface
Parameters:
- `DW`, 16, datapath width (≥4)
- `NREG`, 8, register count (power of 2, ≥2); `AW = $clog2(NREG)`
- `PCW`, 8, program-counter width (≤DW)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high only in IDLE
- `cmd_alu_op`  in  2  00 ADD, 01 SUB, 10 AND, 11 NOT-B
- `cmd_shift`  in  2  00 pass, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- `cmd_rn`, `cmd_rm`, `cmd_rd`  in  AW each  A source, B source, destination
- `cmd_a_zero`  in  1  force ALU A input to 0
- `cmd_b_imm`  in  1  ALU B input = `cmd_imm5` instead of shifter output
- `cmd_imm5`  in  DW  sign-extended immediate for B
- `cmd_imm8`  in  DW  sign-extended immediate for writeback
- `cmd_wb_sel`  in  2  00 C, 01 {0,pc}, 10 imm8, 11 mdata
- `cmd_wr_en`  in  1  write `rd` in WB
- `cmd_flags_en`  in  1  update status in EXEC
- `mdata`  in  DW  memory read data, sampled in WB
- `pc`  in  PCW  sampled in WB, zero-extended
- `datapath_out`  out  DW  C register
- `Z_out`, `N_out`, `V_out`  out  1 each  status register
- `done`  out  1  one-cycle pulse in WB
- `dbg_addr`  in  AW  debug read address
- `dbg_data`  out  DW  combinational `regs[dbg_addr]`

## Operation
- All command fields are captured into an internal command register on acceptance (`cmd_valid && cmd_ready`). Inputs may change afterwards.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, WB.
  - IDLE→LOAD_A on acceptance when `cmd_wb_sel==00`.
  - IDLE→WB on acceptance when `cmd_wb_sel!=00`. The ALU path is skipped; C and status are unchanged.
  - LOAD_A→LOAD_B→EXEC→WB→IDLE unconditionally.
- LOAD_A: `A <= regs[rn]`. LOAD_B: `B <= regs[rm]`.
- EXEC: `C <= result`. Status ← {Z,N,V} only if `cmd_flags_en`.
  - Operands: `Ain = a_zero ? 0 : A`; `Bin = b_imm ? imm5 : shift(B)`.
  - `result = DW`-bit wrapped arithmetic of `Ain op Bin`. NOT-B ignores Ain.
- Flag rules:
  - Z = (result==0).
  - N = result[DW-1].
  - ADD: V = (Ain[msb]==Bin[msb]) && (result[msb]!=Ain[msb]).
  - SUB: V = (Ain[msb]!=Bin[msb]) && (result[msb]!=Ain[msb]).
  - AND, NOT: V=0.
- WB: if `cmd_wr_en`, `regs[rd] <= wdata`, selected per `cmd_wb_sel`. `done=1` for this cycle only.
- A, B, C and status hold their value in every state except the one that loads them.
- `rd` may equal `rn` or `rm`. Operands were latched earlier, so the old value is used.

## Timing
- Reset (async assert, sync-safe deassert), all cleared: regs=0, A=B=C=0, Z=N=V=0, state=IDLE, `done=0`. `cmd_ready=1` once `rst_n` is high.
- ALU command: accepted at edge 0. C/flags are visible after edge 3. The register write and `done` pulse occur in the cycle after edge 3; the write is visible on `dbg_data` after edge 4. `cmd_ready` is high again after edge 4.
  - Issue rate: one ALU command per 5 cycles.
- Non-ALU writeback: accepted at edge 0. WB and `done` in the following cycle; write visible after edge 1. Issue rate: one per 2 cycles.
- `cmd_ready` is a function of state only. `cmd_valid` held high while busy is ignored, and the next acceptance is on the first IDLE edge.
- Reset mid-command aborts immediately. No partial write survives (all registers are cleared), and no `done` pulse occurs.
- `mdata` and `pc` must be stable in the WB cycle.

## Test plan
- Reset: hold `rst_n=0` then release. Required: all `dbg_data` reads 0, `cmd_ready=1`, Z=N=V=0, `datapath_out=0`.
- Load immediates: `wb_sel=10`, imm8=0x0005→R0 and imm8=0x0003→R1. Then ADD R2=R0+R1 with flags_en. Required: R2=0x0008, Z=N=V=0, `done` exactly once per command, 2- and 5-cycle spacing.
- SUB overflow (DW=16): R0=0x8000 (via mdata), R1=1, SUB. Required: C=0x7FFF, V=1, N=0, Z=0. Then SUB R1-R1. Required: Z=1, V=0.
- Shift/imm paths: R1=0x8002; ADD with a_zero, rm=R1, shift=11. Required: 0xC001. Repeat with shift=10 → 0x4001, shift=01 → 0x0004. With b_imm, imm5=0xFFFF, ADD R1 → 0x8001.
- Flag/write gating: run NOT with flags_en=0 and wr_en=0. Required: status and register file unchanged, C=~B. Run `wb_sel=01` with pc=0xA5. Required: register=0x00A5.
- Handshake/reset: hold `cmd_valid` continuously with changing fields. Required: only fields present on IDLE edges are executed. Assert `rst_n=0` during EXEC. Required: no `done`, all state 0, next command executes normally.
